// File: rtl/as5401_bus_ctrl_pkg.sv
// Shared constants for the AS5401 bus controller.
// Phase ring codes, data address map and register widths.
package as5401_bus_ctrl_pkg;

  localparam int PC_W  = 12;
  localparam int MAR_W = 8;

  localparam logic [3:0] PH_FETCH  = 4'b0001;
  localparam logic [3:0] PH_DECODE = 4'b0010;
  localparam logic [3:0] PH_EXEC   = 4'b0100;
  localparam logic [3:0] PH_COMMIT = 4'b1000;

  localparam logic [7:0] RAM_LAST = 8'h0F;
  localparam logic [7:0] OUT_LO   = 8'h10;
  localparam logic [7:0] OUT_HI   = 8'h11;
  localparam logic [7:0] IN_ADDR  = 8'h12;

  function automatic logic is_ram(input logic [7:0] a);
    return a <= RAM_LAST;
  endfunction

endpackage

// File: rtl/as5401_dram.sv
// 16x4 data RAM: one synchronous write port, one
// combinational read port, synchronous clear.
module as5401_dram (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [3:0] wdata,
  input  logic [3:0] raddr,
  output logic [3:0] rdata
);

  logic [3:0] r_mem [16];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/as5401_bus_ctrl.sv
// AS5401 bus controller: PC, MAR, data RAM and I/O ports,
// all committed on the phase==COMMIT clock edge.
module as5401_bus_ctrl
  import as5401_bus_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      cpu_dout,
  input  logic [3:0]      phase,
  input  logic            write_flag,
  input  logic            mar_flag,
  input  logic            jmp_flag,
  input  logic [3:0]      prog_data,
  input  logic [3:0]      in_port,
  output logic [PC_W-1:0] prog_addr,
  output logic [3:0]      insin,
  output logic [3:0]      din,
  output logic [7:0]      out_port
);

  logic [PC_W-1:0]  r_pc;
  logic [MAR_W-1:0] r_mar;
  logic [3:0]       r_din;
  logic [7:0]       r_out;

  logic             w_commit;
  logic             w_wr;
  logic             w_ram_we;
  logic [MAR_W-1:0] w_mar_nxt;
  logic [3:0]       w_ram_rd;
  logic [3:0]       w_rd;

  assign w_commit  = (phase == PH_COMMIT);
  assign w_wr      = w_commit & write_flag;
  assign w_ram_we  = w_wr & is_ram(r_mar);
  assign w_mar_nxt = (w_commit & mar_flag)
                   ? {r_mar[3:0], cpu_dout}
                   : r_mar;

  as5401_dram u_dram (
    .clk   (clk),
    .rst   (rst),
    .we    (w_ram_we),
    .waddr (r_mar[3:0]),
    .wdata (cpu_dout),
    .raddr (w_mar_nxt[3:0]),
    .rdata (w_ram_rd)
  );

  // din sees the post-edge MAR and RAM, so bypass a same-edge write
  always_comb begin
    w_rd = '0;
    if (is_ram(w_mar_nxt)) begin
      if (w_ram_we && (r_mar[3:0] == w_mar_nxt[3:0]))
        w_rd = cpu_dout;
      else
        w_rd = w_ram_rd;
    end else if (w_mar_nxt == IN_ADDR) begin
      w_rd = in_port;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= '0;
      r_mar <= '0;
      r_din <= '0;
      r_out <= '0;
    end else begin
      r_din <= w_rd;
      if (w_commit) begin
        r_pc  <= jmp_flag ? {r_mar, cpu_dout} : r_pc + 1'b1;
        r_mar <= w_mar_nxt;
        if (w_wr && (r_mar == OUT_LO)) r_out[3:0] <= cpu_dout;
        if (w_wr && (r_mar == OUT_HI)) r_out[7:4] <= cpu_dout;
      end
    end
  end

  assign prog_addr = r_pc;
  assign insin     = prog_data;
  assign din       = r_din;
  assign out_port  = r_out;

endmodule

// File: tb/tb_as5401_bus_ctrl.sv
// Testbench for as5401_bus_ctrl: ring-level vector table,
// reset corner sequence, randomized run vs reference model.
module tb_as5401_bus_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  cpu_dout;
  logic [3:0]  phase;
  logic        write_flag;
  logic        mar_flag;
  logic        jmp_flag;
  logic [3:0]  prog_data;
  logic [3:0]  in_port;
  logic [11:0] prog_addr;
  logic [3:0]  insin;
  logic [3:0]  din;
  logic [7:0]  out_port;

  int errors = 0;
  int checks = 0;

  as5401_bus_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_dout   (cpu_dout),
    .phase      (phase),
    .write_flag (write_flag),
    .mar_flag   (mar_flag),
    .jmp_flag   (jmp_flag),
    .prog_data  (prog_data),
    .in_port    (in_port),
    .prog_addr  (prog_addr),
    .insin      (insin),
    .din        (din),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          w;
    bit          m;
    bit          j;
    logic [3:0]  d;
    logic [11:0] pc;
    logic [3:0]  dn;
    logic [7:0]  op;
  } vec_t;

  vec_t vt[$];

  // reference model state
  logic [11:0] m_pc;
  logic [7:0]  m_mar;
  logic [3:0]  m_ram [16];
  logic [7:0]  m_out;
  logic [3:0]  m_din;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic [3:0] ph, input bit w,
                      input bit m, input bit j,
                      input logic [3:0] d);
    @(negedge clk);
    phase = ph;
    write_flag = w;
    mar_flag = m;
    jmp_flag = j;
    cpu_dout = d;
    @(posedge clk);
    #1;
  endtask

  task automatic ring(input bit w, input bit m, input bit j,
                      input logic [3:0] d);
    tick(4'b0001, 0, 0, 0, 4'h0);
    tick(4'b0010, 0, 0, 0, 4'h0);
    tick(4'b0100, 0, 0, 0, 4'h0);
    tick(4'b1000, w, m, j, d);
    tick(4'b0001, 0, 0, 0, 4'h0);
  endtask

  function automatic logic [3:0] m_read(input logic [7:0] a,
                                        input logic [3:0] ip);
    if (a <= 8'h0F) return m_ram[a[3:0]];
    if (a == 8'h12) return ip;
    return 4'h0;
  endfunction

  task automatic model_edge();
    logic [7:0] old_mar;
    if (rst) begin
      m_pc = 0;
      m_mar = 0;
      m_out = 0;
      m_din = 0;
      for (int i = 0; i < 16; i++) m_ram[i] = 0;
      return;
    end
    if (phase == 4'b1000) begin
      old_mar = m_mar;
      if (write_flag) begin
        if (old_mar < 16) m_ram[old_mar[3:0]] = cpu_dout;
        else if (old_mar == 8'h10) m_out[3:0] = cpu_dout;
        else if (old_mar == 8'h11) m_out[7:4] = cpu_dout;
      end
      if (jmp_flag) m_pc = {old_mar, cpu_dout};
      else m_pc = 12'((int'(m_pc) + 1) % 4096);
      if (mar_flag) m_mar = {old_mar[3:0], cpu_dout};
    end
    m_din = m_read(m_mar, in_port);
  endtask

  initial begin
    rst = 1'b1;
    phase = 4'b0001;
    write_flag = 0;
    mar_flag = 0;
    jmp_flag = 0;
    cpu_dout = 0;
    prog_data = 4'h6;
    in_port = 4'h3;

    // {w,m,j,d, pc, din, out} after each ring
    for (int i = 1; i <= 5; i++)
      vt.push_back('{0,0,0,4'h0, 12'(i), 4'h0, 8'h00});
    vt.push_back('{0,1,0,4'h1, 12'h006, 4'h0, 8'h00});
    vt.push_back('{0,1,0,4'h0, 12'h007, 4'h0, 8'h00});
    vt.push_back('{1,0,0,4'hA, 12'h008, 4'h0, 8'h0A});
    vt.push_back('{0,1,0,4'h0, 12'h009, 4'h0, 8'h0A});
    vt.push_back('{0,1,0,4'h5, 12'h00A, 4'h0, 8'h0A});
    vt.push_back('{1,0,0,4'h7, 12'h00B, 4'h7, 8'h0A});
    vt.push_back('{0,1,0,4'h1, 12'h00C, 4'h0, 8'h0A});
    vt.push_back('{0,1,0,4'h2, 12'h00D, 4'h3, 8'h0A});
    vt.push_back('{0,1,0,4'hA, 12'h00E, 4'h0, 8'h0A});
    vt.push_back('{0,1,0,4'hB, 12'h00F, 4'h0, 8'h0A});
    vt.push_back('{0,0,1,4'hC, 12'hABC, 4'h0, 8'h0A});
    vt.push_back('{0,0,0,4'h0, 12'hABD, 4'h0, 8'h0A});
    vt.push_back('{0,1,0,4'h0, 12'hABE, 4'h0, 8'h0A});
    vt.push_back('{0,1,0,4'h2, 12'hABF, 4'h0, 8'h0A});
    vt.push_back('{1,1,0,4'h9, 12'hAC0, 4'h0, 8'h0A});
    vt.push_back('{0,1,0,4'h0, 12'hAC1, 4'h0, 8'h0A});
    vt.push_back('{0,1,0,4'h2, 12'hAC2, 4'h9, 8'h0A});
    vt.push_back('{0,1,0,4'hF, 12'hAC3, 4'h0, 8'h0A});
    vt.push_back('{0,1,0,4'hF, 12'hAC4, 4'h0, 8'h0A});
    vt.push_back('{0,0,1,4'hF, 12'hFFF, 4'h0, 8'h0A});
    vt.push_back('{0,0,0,4'h0, 12'h000, 4'h0, 8'h0A});
    vt.push_back('{1,0,0,4'h5, 12'h001, 4'h0, 8'h0A});
    vt.push_back('{0,1,0,4'h0, 12'h002, 4'h0, 8'h0A});
    vt.push_back('{0,1,0,4'h2, 12'h003, 4'h9, 8'h0A});

    repeat (2) @(posedge clk);
    #1;
    chk("reset prog_addr", prog_addr, 12'h000);
    chk("reset din", din, 4'h0);
    chk("reset out_port", out_port, 8'h00);
    chk("reset insin", insin, 4'h6);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < vt.size(); k++) begin
      ring(vt[k].w, vt[k].m, vt[k].j, vt[k].d);
      chk($sformatf("vec%0d prog_addr", k), prog_addr, vt[k].pc);
      chk($sformatf("vec%0d din", k), din, vt[k].dn);
      chk($sformatf("vec%0d out_port", k), out_port, vt[k].op);
    end

    // reset on a commit edge with jmp pending
    tick(4'b0010, 0, 0, 0, 4'h0);
    tick(4'b0100, 0, 0, 0, 4'h0);
    @(negedge clk);
    phase = 4'b1000;
    jmp_flag = 1;
    cpu_dout = 4'hC;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst commit prog_addr", prog_addr, 12'h000);
    chk("rst commit din", din, 4'h0);
    chk("rst commit out_port", out_port, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    jmp_flag = 0;
    phase = 4'b0001;
    ring(0, 0, 0, 4'h0);
    chk("post-rst first inc", prog_addr, 12'h001);
    ring(0, 1, 0, 4'h2);
    chk("post-rst RAM[2] cleared", din, 4'h0);

    // non-one-hot phase must not commit
    tick(4'b1100, 1, 1, 1, 4'h7);
    tick(4'b1111, 1, 1, 1, 4'h7);
    chk("bad phase prog_addr", prog_addr, 12'h002);
    chk("bad phase din", din, 4'h0);

    // randomized run against the reference model
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      rst = (n == 0) || ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 4) == 0) phase = 4'($urandom_range(0, 15));
      else phase = 4'(1 << $urandom_range(0, 3));
      write_flag = 1'($urandom_range(0, 1));
      mar_flag = 1'($urandom_range(0, 1));
      jmp_flag = 1'($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) cpu_dout = 4'($urandom_range(0, 2));
      else cpu_dout = 4'($urandom_range(0, 15));
      prog_data = 4'($urandom_range(0, 15));
      in_port = 4'($urandom_range(0, 15));
      @(posedge clk);
      model_edge();
      #1;
      chk("rand prog_addr", prog_addr, m_pc);
      chk("rand din", din, m_din);
      chk("rand out_port", out_port, m_out);
      chk("rand insin", insin, prog_data);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/as5401_bus_ctrl.md
AS5401_BUS_CTRL -- requirements
Module: as5401_bus_ctrl

Interface
REQ-001 The block SHALL use one clock and one reset: reset is synchronous and active-high, and the ports are named clk and rst.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_dout  in  4  CPU data/RR nibble
- phase  in  4  CPU one-hot phase ring; values 0001, 0010, 0100, 1000
- write_flag  in  1  CPU WRITE flag
- mar_flag  in  1  CPU MAR flag
- jmp_flag  in  1  CPU JMP flag
- prog_data  in  4  nibble from external program memory
- in_port  in  4  external input nibble
- prog_addr  out  12  program counter driven to external program memory
- insin  out  4  instruction nibble to CPU
- din  out  4  data nibble to CPU
- out_port  out  8  latched output port

Function
REQ-003 The block SHALL update state only at the posedge of clk where phase==1000 (the commit edge); at all other edges PC, MAR, RAM and out_port SHALL hold.
REQ-004 The block SHALL drive prog_addr from the 12-bit PC register at all times.
REQ-005 The block SHALL drive insin combinationally equal to prog_data; the block adds no latency on the instruction path.
REQ-006 At the commit edge, if jmp_flag==0, PC SHALL increment by 1, wrapping from 0xFFF to 0x000.
REQ-007 At the commit edge, if jmp_flag==1, PC SHALL load {MAR[7:0], cpu_dout}; this load has priority over the increment.
REQ-008 At the commit edge, if mar_flag==1, MAR SHALL shift left one nibble: MAR <= {MAR[3:0], cpu_dout}.
REQ-009 At the commit edge, if write_flag==1, cpu_dout SHALL be written to the address held in MAR before any same-edge MAR update.
- The write uses the old MAR.
- MAR, write and JMP may all occur on the same edge; each uses pre-edge values.
REQ-010 Address map for writes:
- 0x00-0x0F: internal 16x4 RAM
- 0x10: out_port[3:0]
- 0x11: out_port[7:4]
- all other addresses: write ignored
REQ-011 Address map for reads:
- 0x00-0x0F: RAM
- 0x12: in_port
- all other addresses: 0
REQ-012 din SHALL be registered: at every posedge, din <= read(MAR) using post-edge-update semantics.
- din reflects a MAR change or a RAM write one clock after the commit edge.
REQ-013 A non-one-hot phase value SHALL cause no commit.

Reset
REQ-014 When rst==1 at a posedge, the block SHALL clear PC, MAR, din, out_port and all 16 RAM nibbles to 0.
REQ-015 Reset SHALL take precedence over a simultaneous commit edge.
- A commit pending when rst is asserted is discarded.
- The first commit after reset release increments PC from 0.
REQ-016 Reset values of the outputs SHALL be:
- prog_addr = 0x000
- din = 0
- out_port = 0x00
- insin follows prog_data

Structure
REQ-017 A shared package SHALL hold the following constants:
- the phase constants (PH_FETCH=0001 ... PH_COMMIT=1000)
- the address map constants (RAM_LAST=0x0F, OUT_LO=0x10, OUT_HI=0x11, IN_ADDR=0x12)
- widths PC_W=12 and MAR_W=8
REQ-018 The 16x4 RAM SHALL be a sub-module as5401_dram with:
- one synchronous write port (we, waddr[3:0], wdata[3:0])
- one combinational read port
- synchronous clear on rst

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset, then 5 full phase rings with all flags 0 -> prog_addr steps 0x000 to 0x005; din=0; out_port=0x00.
- mar_flag on two consecutive rings with cpu_dout 0x1 then 0x0, then write_flag with cpu_dout 0xA -> out_port=0x0A; RAM unchanged.
- MAR=0x05, then write_flag with 0x7 -> din=0x7 one clock after the commit edge; read of address 0x12 with in_port=0x3 -> din=0x3.
- MAR=0xAB, then jmp_flag with cpu_dout 0xC -> prog_addr=0xABC; next plain ring -> 0xABD; from PC=0xFFF a plain ring gives 0x000.
- write_flag and mar_flag in the same ring, MAR=0x02, cpu_dout 0x9 -> RAM[2]=0x9; MAR=0x29.
- rst asserted on a commit edge with jmp_flag=1 -> prog_addr=0x000; no jump; RAM cleared.
